// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU scheduler: widths, opcode constants and FSM states.
// Also provides the shift-op decode used by both the scheduler and the ALU.
package alu_ctrl_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;
    localparam int OP_W    = 4;
    localparam int NUM_REQ = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_NOTA = 4'd5;
    localparam logic [OP_W-1:0] OP_NOTB = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL1 = 4'd7;
    localparam logic [OP_W-1:0] OP_SHR1 = 4'd8;
    localparam logic [OP_W-1:0] OP_PASS = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        return (op == OP_SHL1) || (op == OP_SHR1);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU; shifts move one bit per use, carry only from ADD.
// Selects 9..15 pass operand A through unchanged.
module alu
    import alu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y     = a;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOTA: y = ~a;
            OP_NOTB: y = ~b;
            OP_SHL1: y = {a[DATA_W-2:0], 1'b0};
            OP_SHR1: y = {1'b0, a[DATA_W-1:1]};
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester round-robin front end for the shared ALU: IDLE grants, EXEC iterates
// the ALU (one shift per cycle for shift ops), RESP holds the result until consumed.
module alu_scheduler
    import alu_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*OP_W-1:0]    req_op,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_carry,
    output logic                       busy
);

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [DATA_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]    b_q, b_d;
    logic                 id_q, id_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_carry_q, rsp_carry_d;
    logic                 rsp_id_q, rsp_id_d;

    logic [OP_W-1:0]      op_arr    [NUM_REQ];
    logic [DATA_W-1:0]    a_arr     [NUM_REQ];
    logic [DATA_W-1:0]    b_arr     [NUM_REQ];
    logic [SHAMT_W-1:0]   shamt_arr [NUM_REQ];

    logic                 grant_id;
    logic                 accept;
    logic [OP_W-1:0]      sel_op;
    logic [DATA_W-1:0]    sel_a;
    logic [DATA_W-1:0]    sel_b;
    logic [SHAMT_W-1:0]   sel_sh;
    logic                 sel_shift;

    logic [OP_W-1:0]      alu_op;
    logic [DATA_W-1:0]    alu_y;
    logic                 alu_carry;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_id = ~last_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign op_arr[gi]    = req_op[gi*OP_W +: OP_W];
            assign a_arr[gi]     = req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi]     = req_b[gi*DATA_W +: DATA_W];
            assign shamt_arr[gi] = req_shamt[gi*SHAMT_W +: SHAMT_W];
            assign req_ready[gi] = rst_n && (state_q == ST_IDLE) && req_valid[gi]
                                   && (grant_id == 1'(gi));
        end
    endgenerate

    assign accept = |req_ready;

    always_comb begin
        sel_op    = op_arr[grant_id];
        sel_a     = a_arr[grant_id];
        sel_b     = b_arr[grant_id];
        sel_sh    = shamt_arr[grant_id];
        sel_shift = is_shift_op(sel_op);
    end

    alu u_alu (
        .op    (alu_op),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_id_d    = rsp_id_q;
        alu_op      = OP_PASS;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = grant_id;
                    last_d  = grant_id;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    carry_d = 1'b0;
                    // A zero-count shift degenerates to a single pass-A step.
                    op_d    = (sel_shift && (sel_sh == '0)) ? OP_PASS : sel_op;
                    cnt_d   = (sel_shift && (sel_sh != '0)) ? sel_sh : SHAMT_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // a_q doubles as the accumulator; a final pass-A cycle loads the response.
                if (cnt_q != '0) begin
                    alu_op  = op_q;
                    a_d     = alu_y;
                    carry_d = alu_carry;
                    cnt_d   = cnt_q - SHAMT_W'(1);
                end else begin
                    rsp_data_d  = alu_y;
                    rsp_carry_d = carry_q;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            op_q        <= OP_PASS;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: accepts push a modelled result, responses pop it.
// A negedge monitor also checks grant order, latency and req_ready gating.
module tb_alu_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        busy;

    always #5 clk = ~clk;

    alu_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        carry;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   rsp_cnt = 0;
    logic rsp_seen = 1'b0;
    logic m_last   = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] sh);
        logic [16:0] r;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {1'b0, 16'(a - b)};
            4'd2:    r = {1'b0, a & b};
            4'd3:    r = {1'b0, a | b};
            4'd4:    r = {1'b0, a ^ b};
            4'd5:    r = {1'b0, ~a};
            4'd6:    r = {1'b0, ~b};
            4'd7:    r = {1'b0, 16'(a << sh)};
            4'd8:    r = {1'b0, a >> sh};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t        e;
        logic        gid;
        logic [3:0]  mop;
        logic [3:0]  msh;
        logic [16:0] r;
        if (!rst_n) begin
            check_eq("rdy_in_reset", {30'd0, req_ready}, 32'd0);
            sb.delete();
            rsp_seen = 1'b0;
            m_last   = 1'b1;
        end else begin
            if (busy) check_eq("rdy_while_busy", {30'd0, req_ready}, 32'd0);
            if (|req_ready) begin
                gid = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                check_eq("grant", {30'd0, req_ready}, gid ? 32'd2 : 32'd1);
                mop = req_op[4*gid +: 4];
                msh = req_shamt[4*gid +: 4];
                r   = model(mop, req_a[16*gid +: 16], req_b[16*gid +: 16], msh);
                e.id       = gid;
                e.data     = r[15:0];
                e.carry    = r[16];
                e.lat      = ((mop == 4'd7 || mop == 4'd8) && msh != 4'd0) ? int'(msh) + 1 : 2;
                e.acc_edge = cyc + 1;
                sb.push_back(e);
                grant_log.push_back(int'(gid));
                m_last = gid;
                $display("accept id=%0d op=%0d exp_data=0x%04h exp_carry=%0d", gid, mop, e.data, e.carry);
            end
            if (rsp_valid && !rsp_seen) begin
                rsp_seen = 1'b1;
                check_eq("rsp_pending", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                    check_eq("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                    check_eq("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.carry});
                    check_eq("rsp_latency", cyc - e.acc_edge, e.lat);
                    $display("response id=%0d data=0x%04h carry=%0d", rsp_id, rsp_data, rsp_carry);
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen = 1'b0;
                rsp_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] sh);
        req_op[4*id +: 4]     = op;
        req_a[16*id +: 16]    = a;
        req_b[16*id +: 16]    = b;
        req_shamt[4*id +: 4]  = sh;
    endtask

    task automatic issue(input int id, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] sh);
        logic got;
        got = 1'b0;
        set_req(id, op, a, b, sh);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = req_ready[id];
            tick();
        end
        req_valid[id] = 1'b0;
        check_eq("accept_wait", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_rsp(input int start);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            done = (rsp_cnt > start);
        end
        check_eq("rsp_wait", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int   start;
        int   n0;
        int   nbusy;
        logic ok;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_shamt = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        tick();
        req_valid = 2'b00;
        rst_n     = 1'b1;
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        check_eq("reset_rsp_carry", {31'd0, rsp_carry}, 32'd0);
        check_eq("reset_rsp_id", {31'd0, rsp_id}, 32'd0);

        // ADD with carry out
        start = rsp_cnt;
        issue(0, 4'd0, 16'hFFFF, 16'h0001, 4'd0);
        wait_rsp(start);

        // Continuous tie after reset: grants must alternate 0,1,0
        do_reset();
        set_req(0, 4'd1, 16'h0005, 16'h0003, 4'd0);
        set_req(1, 4'd4, 16'hF0F0, 16'h0FF0, 4'd0);
        n0 = grant_log.size();
        req_valid = 2'b11;
        for (int i = 0; i < 40 && grant_log.size() < n0 + 3; i++) tick();
        req_valid = 2'b00;
        check_eq("rr_count", grant_log.size() - n0, 3);
        if (grant_log.size() >= n0 + 3) begin
            check_eq("rr_grant0", grant_log[n0], 0);
            check_eq("rr_grant1", grant_log[n0+1], 1);
            check_eq("rr_grant2", grant_log[n0+2], 0);
        end
        for (int i = 0; i < 40 && (busy || sb.size() != 0); i++) tick();
        check_eq("rr_drained", {31'd0, busy}, 32'd0);

        // Long shift: 16 edges from accept to response
        start = rsp_cnt;
        issue(1, 4'd7, 16'h0001, 16'h0000, 4'd15);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
            else if (busy) nbusy++;
        end
        check_eq("shl_busy_edges", nbusy, 16);
        wait_rsp(start);

        // Zero-count shift returns A unchanged
        start = rsp_cnt;
        issue(1, 4'd8, 16'h8000, 16'h0000, 4'd0);
        wait_rsp(start);

        // Opcode 12 passes A
        start = rsp_cnt;
        issue(0, 4'd12, 16'h1234, 16'h5555, 4'd0);
        wait_rsp(start);

        // Backpressure in RESP while requester inputs change
        rsp_ready = 1'b0;
        issue(0, 4'd3, 16'h00F0, 16'h0F00, 4'd0);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        set_req(1, 4'd0, 16'h1111, 16'h2222, 4'd0);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            req_a = ~req_a;
            tick();
            check_eq("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("hold_data", {16'd0, rsp_data}, 32'h0FF0);
            check_eq("hold_id", {31'd0, rsp_id}, 32'd0);
            check_eq("hold_carry", {31'd0, rsp_carry}, 32'd0);
            check_eq("hold_req_ready", {30'd0, req_ready}, 32'd0);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        check_eq("release_idle", {31'd0, busy}, 32'd0);
        check_eq("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset in the middle of an 8-step shift
        issue(0, 4'd7, 16'h0003, 16'h0000, 4'd8);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        start = rsp_cnt;
        for (int i = 0; i < 12; i++) tick();
        check_eq("midrst_no_rsp", rsp_cnt - start, 0);
        set_req(0, 4'd2, 16'hFF0F, 16'h0FF0, 4'd0);
        set_req(1, 4'd6, 16'h0000, 16'h00FF, 4'd0);
        n0 = grant_log.size();
        req_valid = 2'b11;
        for (int i = 0; i < 20 && grant_log.size() == n0; i++) tick();
        req_valid = 2'b00;
        check_eq("midrst_tie_grant", (grant_log.size() > n0) ? grant_log[n0] : -1, 0);
        wait_rsp(start);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state updates on its rising edge), then rst_n input 1 (synchronous, active-low).
REQ-002 The block SHALL have req_valid input 2: bit i means requester i presents a command.
REQ-003 The block SHALL have req_ready output 2: bit i means requester i's command is accepted on this edge when req_valid[i] is also high.
REQ-004 The block SHALL have req_op input 8: [4i+3:4i] is the ALU select of requester i.
REQ-005 The block SHALL have req_a input 32: [16i+15:16i] is operand A of requester i.
REQ-006 The block SHALL have req_b input 32: [16i+15:16i] is operand B of requester i.
REQ-007 The block SHALL have req_shamt input 8: [4i+3:4i] is the shift count of requester i, used only by ops 7 and 8.
REQ-008 The block SHALL have rsp_valid output 1 (response available), rsp_ready input 1 (consumer accepts the response), rsp_id output 1 (requester index), rsp_data output 16 (result) and rsp_carry output 1 (carry flag).
REQ-009 The block SHALL have busy output 1: high whenever state is not IDLE.

Function
REQ-010 Ops SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 NOT B, 7 SHL1, 8 SHR1, 9-15 pass A; all 16-bit, modulo 2^16.
REQ-011 The FSM SHALL have states IDLE, EXEC and RESP; these are its only states.
REQ-012 In IDLE, req_ready SHALL be one-hot on the granted requester, or zero if req_valid==0; in EXEC and RESP, req_ready SHALL be 0.
REQ-013 Arbitration SHALL be round-robin: a lone valid requester is granted; when both are valid, the requester not granted last wins.
REQ-014 On the accept edge the block SHALL capture op, A, B, shamt and id, update the last-grant pointer, and enter EXEC.
REQ-015 The EXEC cycle count N SHALL be 1 for ops other than 7/8; for ops 7/8, N = shamt when shamt>=1.
REQ-016 Ops 7/8 with shamt=0 SHALL take N=1 and return A unchanged.
REQ-017 For ops 7/8, each EXEC cycle SHALL apply one ALU shift and write the result back as the next A, so the final result is A shifted by shamt with zero fill.
REQ-018 On the last EXEC edge the block SHALL register rsp_data, rsp_carry and rsp_id, and enter RESP with rsp_valid=1.
REQ-019 rsp_valid SHALL rise exactly N+1 edges after the accept edge; the total range is 2..16 edges.
REQ-020 rsp_carry SHALL be bit 16 of the 17-bit sum {0,A}+{0,B} for ADD, and 0 for every other op.
REQ-021 In RESP, rsp_valid, rsp_data, rsp_carry and rsp_id SHALL hold stable until rsp_ready=1.
REQ-022 On the edge where rsp_ready=1 in RESP, the block SHALL clear rsp_valid and return to IDLE; the next accept is possible one edge later (no same-cycle re-grant).
REQ-023 rsp_ready asserted outside RESP SHALL be ignored.
REQ-024 req_* inputs changing during EXEC or RESP SHALL not affect the operation in flight.
REQ-025 The ALU select driven in IDLE and RESP SHALL be 4'b1111 (pass A); operand values there are don't-care.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0, busy=0, req_ready=0 and the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-027 Reset mid-EXEC or mid-RESP SHALL abandon the operation with no response issued.
REQ-028 req_ready SHALL be forced 0 while rst_n=0.

Structure
REQ-029 A shared package alu_ctrl_pkg SHALL hold the 4-bit opcode constants, the FSM state enum, and the data width (16) and shift-count width (4) parameters.
REQ-030 The existing 16-bit ALU SHALL be instantiated as the single sub-module alu.
REQ-031 The scheduler SHALL contain only registers, the FSM, the arbiter and the operand mux, and SHALL add no arithmetic beyond a 4-bit down-counter.

Verification
REQ-032 Bench: req0 ADD A=0xFFFF B=0x0001, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_data=0x0000, rsp_carry=1, rsp_id=0.
REQ-033 Bench: both requesters valid continuously after reset (req0 SUB 5-3, req1 XOR 0xF0F0^0x0FF0) -> grants alternate 0,1,0; data 0x0002 and 0xFF00.
REQ-034 Bench: req1 SHL1 A=0x0001 shamt=15 -> busy for 16 edges, rsp_data=0x8000, rsp_carry=0; then SHR1 A=0x8000 shamt=0 -> rsp_data=0x8000 after 2 edges.
REQ-035 Bench: rsp_ready held 0 for 5 cycles in RESP while req_a toggles -> outputs stable, req_ready=0 throughout, release returns to IDLE one edge later.
REQ-036 Bench: rst_n=0 for one edge during an EXEC of shamt=8 -> next cycle IDLE, rsp_valid=0, no response emitted; a following tie is granted to req0.
REQ-037 Bench: op 12 A=0x1234 -> rsp_data=0x1234, rsp_carry=0 after 2 edges.
